// File: rtl/rcv_control_fsm.sv
// Receive-side sequencer for the USB bit-timing datapath: gates the bit timer,
// checks the SYNC byte, counts payload bytes and strobes one FIFO write per byte.
module rcv_control_fsm #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_BYTES = 64,
  parameter int         CNT_BITS  = 7
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                d_edge,
  input  logic                eop,
  input  logic                shift_enable,
  input  logic                byte_received,
  input  logic [7:0]          rcv_data,
  input  logic                fifo_full,
  output logic                rcving,
  output logic                w_enable,
  output logic                r_error,
  output logic [CNT_BITS-1:0] byte_count
);

  typedef enum logic [2:0] {
    IDLE, SYNC, RCV, STORE, EOP_WAIT, ERR, ERR_EOP, EIDLE
  } state_t;

  localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_BYTES);

  // state is left as a plain named signal so checkers can bind to it directly.
  state_t              state, state_n;
  logic [2:0]          bit_cnt, bit_cnt_n;
  logic [CNT_BITS-1:0] byte_count_n;
  logic                wr_ok, wr_ok_n;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      byte_count <= '0;
      wr_ok      <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      byte_count <= byte_count_n;
      wr_ok      <= wr_ok_n;
    end
  end

  // The store/overrun decision is captured on the way into STORE so that
  // w_enable is decoded purely from registers (no fifo_full -> w_enable path).
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    byte_count_n = byte_count;
    wr_ok_n      = wr_ok;

    if ((state == SYNC || state == RCV) && shift_enable)
      bit_cnt_n = bit_cnt + 3'd1;

    case (state)
      IDLE, EIDLE: begin
        if (d_edge) begin
          state_n      = SYNC;
          bit_cnt_n    = 3'd0;
          byte_count_n = '0;
        end
      end
      SYNC: begin
        if (eop && shift_enable)
          state_n = ERR;
        else if (byte_received)
          state_n = (rcv_data == SYNC_BYTE) ? RCV : ERR;
      end
      RCV: begin
        // A bit sampled during SE0 ends the packet; eop beats byte_received.
        if (eop && shift_enable)
          state_n = (bit_cnt == 3'd0) ? EOP_WAIT : ERR;
        else if (byte_received) begin
          state_n = STORE;
          wr_ok_n = !fifo_full && (byte_count != MAX_CNT);
        end
      end
      STORE: begin
        wr_ok_n = 1'b0;
        if (wr_ok) begin
          byte_count_n = byte_count + CNT_BITS'(1);
          state_n      = RCV;
        end else begin
          state_n = ERR;
        end
      end
      EOP_WAIT: if (!eop && d_edge) state_n = IDLE;
      ERR:      if (eop)            state_n = ERR_EOP;
      ERR_EOP:  if (!eop && d_edge) state_n = EIDLE;
      default:  state_n = IDLE;
    endcase
  end

  assign rcving   = (state == SYNC) || (state == RCV) || (state == STORE) ||
                    (state == EOP_WAIT);
  assign w_enable = (state == STORE) && wr_ok;
  assign r_error  = (state == ERR) || (state == ERR_EOP) || (state == EIDLE);

endmodule

// File: doc/rcv_control_fsm.md
Name: rcv_control_fsm

Overview:
Receive-side sequencer for the USB bit-timing datapath. Starts and stops bit timing via `rcving` and validates the SYNC byte. Tracks bit and byte alignment from the timer's `shift_enable`/`byte_received` strobes. Issues one FIFO write strobe per payload byte and flags framing, overrun and length errors. Sits between the edge/EOP detectors, the bit timer plus shift register, and the RX FIFO.

Parameters:
- SYNC_BYTE, 8'h80, value the first received byte must equal (post-shift bit order).
- MAX_BYTES, 64, maximum payload bytes per packet after SYNC; must be at most 127.
- CNT_BITS, 7, width of `byte_count`; must satisfy 2^CNT_BITS > MAX_BYTES.

Ports:
- clk  in  1  system clock, all state on posedge.
- n_rst  in  1  asynchronous active-low reset.
- d_edge  in  1  one-cycle pulse on a D+/D- transition.
- eop  in  1  level, high while the bus is in SE0.
- shift_enable  in  1  one-cycle pulse, bit sampled this cycle (from timer).
- byte_received  in  1  one-cycle pulse coincident with the 8th `shift_enable` of a byte.
- rcv_data  in  8  shift-register contents, valid in the cycle `byte_received` is high.
- fifo_full  in  1  RX FIFO cannot accept a write.
- rcving  out  1  enables the bit timer; high while a packet is in progress.
- w_enable  out  1  one-cycle FIFO write strobe.
- r_error  out  1  sticky receive-error flag.
- byte_count  out  CNT_BITS  payload bytes stored in the current packet.

Behaviour:
- Reset (async, n_rst=0): state=IDLE; rcving=0, w_enable=0, r_error=0, byte_count=0, internal bit_cnt=0.
- All outputs are Moore: decoded from the registered state plus registered counters, with no combinational input-to-output path.
- bit_cnt (3 bits):
  - Increments on `shift_enable` while in RCV or SYNC.
  - Wraps 7->0; `byte_received` coincides with the wrap.
  - Cleared on entry to SYNC.

States and transitions (each transition takes effect at the next posedge):
- IDLE (rcving=0):
  - d_edge=1 -> SYNC; clear byte_count and bit_cnt.
  - rcving is high the cycle after d_edge.
- SYNC (rcving=1):
  - eop=1 && shift_enable=1 -> ERR.
  - byte_received=1 && rcv_data==SYNC_BYTE -> RCV.
  - byte_received=1 && rcv_data!=SYNC_BYTE -> ERR.
- RCV (rcving=1):
  - eop=1 && shift_enable=1 && bit_cnt==0 -> EOP_WAIT (clean end).
  - eop=1 && shift_enable=1 && bit_cnt!=0 -> ERR (partial byte).
  - byte_received=1 -> STORE.
  - eop has priority over byte_received in the same cycle.
- STORE (rcving=1, one cycle):
  - fifo_full=1 or byte_count==MAX_BYTES -> ERR; no write.
  - Otherwise w_enable=1 this cycle, byte_count+=1 at the posedge, -> RCV.
- EOP_WAIT (rcving=1):
  - eop=0 && d_edge=1 (SE0 -> J) -> IDLE; rcving drops the next cycle.
- ERR (rcving=0, r_error=1): eop=1 -> ERR_EOP.
- ERR_EOP (rcving=0, r_error=1): eop=0 && d_edge=1 -> EIDLE.
- EIDLE (rcving=0, r_error=1):
  - d_edge=1 -> SYNC; r_error clears in that transition and byte_count is cleared.
  - r_error is sticky until the next packet start or reset.

Boundary conditions:
- byte_count saturates at MAX_BYTES; it is never written beyond that.
- The byte_count value reached is held after EOP until the next packet start.
- d_edge pulses while in SYNC, RCV, STORE or ERR are ignored; the timer resyncs from them directly.
- Reset mid-packet: immediate return to reset values; no w_enable is emitted.
- An error while the FIFO is full still produces no write.
- Exactly one w_enable per stored byte; never two consecutive w_enable cycles.

Test Plan:
- Reset during RCV with 3 bytes stored -> all outputs 0 asynchronously, state IDLE, no stray w_enable.
- Valid packet: SYNC 8'h80, then 8'hC3 and 8'hA5, then EOP aligned to a byte boundary, then J edge -> exactly 2 w_enable pulses, each the cycle after byte_received; byte_count=2; r_error=0; rcving drops 1 cycle after the J d_edge.
- Bad sync: first byte 8'h81 -> r_error=1 and rcving=0 the cycle after byte_received; no w_enable. After EOP, J, and a new d_edge, r_error clears and rcving=1.
- Partial byte: SYNC plus 1 byte, then EOP at bit_cnt=3 -> ERR; byte_count=1; r_error sticky through EOP and idle.
- Overrun: fifo_full=1 when the second payload byte arrives -> no w_enable for it; r_error=1; byte_count=1.
- Length limit, MAX_BYTES=4: 5 payload bytes -> 4 w_enable pulses, then r_error=1 on the 5th; byte_count=4.
